uart_tx_frame: RTL and testbench

Parametrised UART transmitter for the serial-output path. It takes one data word through a valid/ready handshake and serialises it as a complete UART frame: start bit, DATA_BITS data bits LSB first, an optional parity bit, and one or two stop bits. An internal baud counter times every bit, so no external bit-rate strobe is needed. It reports frame completion with a one-cycle pulse. It supersedes the fixed 8-bit, even-parity, externally-strobed transmitter.

---
 rtl/uart_tx_frame.sv | 128 ++++++++++++
 tb/tb_uart_tx_frame.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, DATA_BITS data bits LSB first, optional parity,
// one or two stop bits. Each bit is timed by an internal baud counter.
module uart_tx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int BAUD_DIV   = 434,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done_sig,
  output logic                 tx
);

  localparam int              CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0]   BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [3:0]      LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic [3:0]      LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic            ODD       = (PARITY_ODD != 0);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (BAUD_DIV < 2) begin : g_bad_baud_div
    $error("uart_tx_frame: BAUD_DIV must be 2 or more");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (PARITY_EN < 0 || PARITY_EN > 1 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
    $error("uart_tx_frame: PARITY_EN and PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               r_state;
  logic [CW-1:0]        r_baud;
  logic [3:0]           r_idx;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_ready;
  logic                 r_done;

  logic w_bit_end;
  logic w_par_bit;

  assign w_bit_end = (r_baud == BAUD_LAST);
  // Parity accumulator does not yet include the last data bit when it is computed.
  assign w_par_bit = r_par ^ r_shreg[0] ^ ODD;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_idx   <= '0;
      r_shreg <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE) r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
      case (r_state)
        S_IDLE: if (tx_valid) begin
          r_shreg <= tx_data;
          r_par   <= 1'b0;
          r_baud  <= '0;
          r_state <= S_START;
          r_tx    <= 1'b0;
          r_ready <= 1'b0;
        end
        S_START: if (w_bit_end) begin
          r_state <= S_DATA;
          r_idx   <= '0;
          r_tx    <= r_shreg[0];
        end
        S_DATA: if (w_bit_end) begin
          r_par   <= r_par ^ r_shreg[0];
          r_shreg <= r_shreg >> 1;
          if (r_idx == LAST_BIT) begin
            r_idx <= '0;
            if (PARITY_EN != 0) begin
              r_state <= S_PARITY;
              r_tx    <= w_par_bit;
            end else begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end
          end else begin
            r_idx <= r_idx + 1'b1;
            r_tx  <= r_shreg[1];
          end
        end
        S_PARITY: if (w_bit_end) begin
          r_state <= S_STOP;
          r_tx    <= 1'b1;
        end
        S_STOP: if (w_bit_end) begin
          if (r_idx == LAST_STOP) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign tx          = r_tx;
  assign tx_ready    = r_ready;
  assign tx_busy     = ~r_ready;
  assign tx_done_sig = r_done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three configurations share one stimulus stream and are
// compared every cycle against a frame-level reference model.
module tb_uart_tx_frame;

  localparam int B = 4;
  localparam int DB [3] = '{8, 8, 7};
  localparam int PE [3] = '{1, 1, 0};
  localparam int PO [3] = '{0, 1, 0};
  localparam int SB [3] = '{1, 2, 2};

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data  = 8'h00;
  logic [2:0] tx_w, rdy_w, bsy_w, dn_w;

  int         ntests = 0;
  int         nfail  = 0;

  int         m_k     [3];
  logic       m_ready [3];
  logic       m_done  [3];
  logic [7:0] m_word  [3];
  int         n_acc   [3];

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_BITS(8), .BAUD_DIV(B), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
    .sysclk(clk), .rst_n(rst_n), .tx_valid(valid), .tx_data(data),
    .tx_ready(rdy_w[0]), .tx_busy(bsy_w[0]), .tx_done_sig(dn_w[0]), .tx(tx_w[0]));

  uart_tx_frame #(.DATA_BITS(8), .BAUD_DIV(B), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_b (
    .sysclk(clk), .rst_n(rst_n), .tx_valid(valid), .tx_data(data),
    .tx_ready(rdy_w[1]), .tx_busy(bsy_w[1]), .tx_done_sig(dn_w[1]), .tx(tx_w[1]));

  uart_tx_frame #(.DATA_BITS(7), .BAUD_DIV(B), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_c (
    .sysclk(clk), .rst_n(rst_n), .tx_valid(valid), .tx_data(data[6:0]),
    .tx_ready(rdy_w[2]), .tx_busy(bsy_w[2]), .tx_done_sig(dn_w[2]), .tx(tx_w[2]));

  function automatic int nbits(input int c);
    return 1 + DB[c] + PE[c] + SB[c];
  endfunction

  // Bit i of the whole frame: start, data LSB first, optional parity, then stop 1s.
  function automatic logic frame_bit(input int c, input logic [7:0] w, input int i);
    int ones;
    ones = $countones(w);
    if (i == 0) return 1'b0;
    if (i <= DB[c]) return w[i-1];
    if (PE[c] == 1 && i == DB[c] + 1) return 1'((ones + PO[c]) % 2);
    return 1'b1;
  endfunction

  function automatic logic all_idle();
    return (m_k[0] < 0) && (m_k[1] < 0) && (m_k[2] < 0);
  endfunction

  task automatic chk(input string tag, input int c, input logic obs, input logic exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s cfg%0d at %0t: observed %b expected %b", tag, c, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_k[c] = -1; m_ready[c] = 1'b1; m_done[c] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < 3; c++) begin
      m_done[c] = 1'b0;
      if (!rst_n) begin
        m_k[c] = -1; m_ready[c] = 1'b1;
      end else if (m_ready[c] && valid) begin
        m_k[c] = 0; m_ready[c] = 1'b0;
        m_word[c] = 8'(int'(data) % (1 << DB[c]));
        n_acc[c]++;
      end else if (m_k[c] >= 0) begin
        m_k[c]++;
        if (m_k[c] == nbits(c) * B) begin
          m_k[c] = -1; m_ready[c] = 1'b1; m_done[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    logic exp_tx;
    for (int c = 0; c < 3; c++) begin
      exp_tx = (m_k[c] >= 0) ? frame_bit(c, m_word[c], m_k[c] / B) : 1'b1;
      chk("tx", c, tx_w[c], exp_tx);
      chk("tx_ready", c, rdy_w[c], m_ready[c]);
      chk("tx_busy", c, bsy_w[c], !m_ready[c]);
      chk("tx_done_sig", c, dn_w[c], m_done[c]);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles && !all_idle(); i++) tick();
    ntests++;
    assert (all_idle()) else begin
      nfail++;
      $error("FAIL wait_idle at %0t: observed busy expected idle within %0d cycles", $time, max_cycles);
    end
  endtask

  task automatic send(input logic [7:0] w);
    valid = 1'b1;
    data  = w;
    tick();
    valid = 1'b0;
    wait_idle(100);
    repeat (3) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    for (int c = 0; c < 3; c++) n_acc[c] = 0;

    // Reset state, then release between edges.
    repeat (2) tick();
    #2 rst_n = 1'b1;
    repeat (2) tick();

    send(8'hA5);
    send(8'h00);
    send(8'h7F);

    // Back-to-back: valid held high, data switched on the first done cycle.
    for (int c = 0; c < 3; c++) n_acc[c] = 0;
    valid = 1'b1;
    data  = 8'h55;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (m_done[0] || m_done[1] || m_done[2]) data = 8'hAA;
      if (n_acc[0] >= 2 && n_acc[1] >= 2 && n_acc[2] >= 2) break;
    end
    valid = 1'b0;
    wait_idle(100);
    repeat (3) tick();

    // Busy protection: a valid pulse with new data mid-frame must be ignored.
    valid = 1'b1;
    data  = 8'h0F;
    tick();
    valid = 1'b0;
    repeat (10) tick();
    valid = 1'b1;
    data  = 8'hFF;
    tick();
    valid = 1'b0;
    wait_idle(100);
    repeat (3) tick();

    // Reset asserted during a data bit: outputs must return to idle without a clock edge.
    valid = 1'b1;
    data  = 8'hC3;
    tick();
    valid = 1'b0;
    repeat (9) tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) tick();
    #2 rst_n = 1'b1;
    send(8'h3C);

    // Randomized traffic, including valid and data changes while busy.
    for (int i = 0; i < 500; i++) begin
      valid = ($urandom_range(0, 3) == 0);
      data  = 8'($urandom);
      tick();
    end
    valid = 1'b0;
    wait_idle(100);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
